pll_rst_seq: RTL and testbench
==============================

PLL_RST_SEQ -- requirements
Module: pll_rst_seq

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: cycles pll_rst is held per PLL reset pulse.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65536: WAIT_LOCK cycles before a retry.
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before releasing sys_rst.
REQ-004 SHALL have parameter MAX_RETRIES, default 3: timeouts tolerated before FAIL.
REQ-005 SHALL have port CLK, input, 1: 12 MHz board reference clock, the sole clock.
REQ-006 SHALL have port RST, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port pll_lock, input, 1: PLL LOCK, asynchronous to CLK.
REQ-008 SHALL have port restart, input, 1: one-cycle request to re-run the sequence.
REQ-009 SHALL have port pll_rst, output, 1: active-high PLL reset.
REQ-010 SHALL have port sys_rst, output, 1: active-high reset for PLL-clocked logic.
REQ-011 SHALL have port running, output, 1: high only in RUN.
REQ-012 SHALL have port fail, output, 1: high only in FAIL.
REQ-013 SHALL have port retry_cnt, output, 2: timeouts in the current attempt.
REQ-014 SHALL have port lost_cnt, output, 8: lock losses seen in RUN, saturating at 255.
REQ-015 SHALL have port state, output, 3: current state code.

Function
REQ-016 SHALL synchronize pll_lock through two flops to lock_s, and all decisions SHALL use lock_s only.
REQ-017 SHALL implement states PLLRST=0, WAIT_LOCK=1, STABLE=2, RUN=3 and FAIL=4; codes 5-7 SHALL return to PLLRST.
REQ-018 SHALL use one shared cycle counter, cleared on every state change, sized to the largest of the three cycle parameters.
REQ-019 In PLLRST, pll_rst=1 and sys_rst=1, and the block SHALL enter WAIT_LOCK when counter==RST_CYCLES-1.
REQ-020 In WAIT_LOCK, lock_s=1 SHALL go to STABLE; otherwise counter==LOCK_TIMEOUT-1 SHALL go to FAIL if retry_cnt==MAX_RETRIES, else increment retry_cnt and go to PLLRST.
REQ-021 In STABLE, lock_s=0 SHALL return to WAIT_LOCK with retry_cnt unchanged, and counter==STABLE_CYCLES-1 with lock_s=1 SHALL go to RUN.
REQ-022 Entering RUN SHALL clear retry_cnt, giving sys_rst=0 and running=1.
REQ-023 In RUN, lock_s=0 SHALL go to PLLRST, increment lost_cnt (saturating) and reassert sys_rst with the state change.
REQ-024 In FAIL, pll_rst=1, sys_rst=1 and fail=1, and only restart or RST SHALL exit.
REQ-025 restart=1 in any state SHALL go to PLLRST, clearing counter, retry_cnt and fail, with priority over every other transition; lost_cnt SHALL be kept.
REQ-026 pll_rst SHALL be 0 only in WAIT_LOCK, STABLE and RUN; sys_rst SHALL be 0 only in RUN.
REQ-027 All outputs SHALL be registered, loaded from next-state, and change on the same edge as the state register (no combinational decode glitches).
REQ-028 sys_rst SHALL be in the CLK domain; re-synchronization into the PLL clock domain SHALL be done by the consumer.

Reset
REQ-029 RST=1 SHALL set state=PLLRST, counter=0, retry_cnt=0, lost_cnt=0, pll_rst=1, sys_rst=1, running=0, fail=0 and both synchronizer flops to 0.
REQ-030 RST SHALL take priority over restart and over all transitions, including mid-RUN.

Structure
REQ-031 Package pll_seq_pkg SHALL hold the state encoding and the default parameter constants.
REQ-032 A single sub-module sync2 (two-flop synchronizer, 1 bit) SHALL be instantiated for pll_lock; there SHALL be no other hierarchy.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-033 pll_lock held at 1 and RST released -> pll_rst falls after 4 edges, sys_rst falls 13 edges after release, running=1, retry_cnt=0.
REQ-034 pll_lock held at 0 -> exactly 3 pll_rst pulses of 4 cycles, retry_cnt steps 0,1,2, then state=4, fail=1, sys_rst stays 1.
REQ-035 In RUN, pll_lock dropped for 3 cycles -> sys_rst=1 within 3 edges of the drop, lost_cnt=1, and a full re-sequence follows after lock returns.
REQ-036 In STABLE, pll_lock glitches low at count 5 -> return to WAIT_LOCK, then a full 8-cycle STABLE, with retry_cnt unchanged.
REQ-037 In FAIL, restart pulsed -> state=0 next edge, fail=0, retry_cnt=0, and lock then reaches RUN.
REQ-038 RST asserted in RUN with restart=1 on the same cycle -> reset values of REQ-029, lost_cnt=0.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared state encoding and default timing constants for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLLRST    = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_state_e;

  localparam int unsigned DEF_RST_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 65536;
  localparam int unsigned DEF_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_MAX_RETRIES   = 3;

  // Largest of three cycle counts; sizes the shared sequencer counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/pll_rst_seq_sync2.sv
// Two-flop synchronizer for a single asynchronous level into the CLK domain.
module sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Both stages clear on reset so a stale lock cannot leak through after RST.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses pll_rst, waits for a stable lock, then releases sys_rst.
//
//  state     | meaning
//  ----------+----------------------------------------------------------
//  PLLRST    | PLL held in reset for RST_CYCLES
//  WAIT_LOCK | PLL released, waiting for synchronized lock (with timeout)
//  STABLE    | lock must stay high for STABLE_CYCLES consecutive cycles
//  RUN       | sys_rst released; a lock drop re-sequences and counts a loss
//  FAIL      | too many timeouts; parked until restart or RST
module pll_rst_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       running,
  output logic       fail,
  output logic [1:0] retry_cnt,
  output logic [7:0] lost_cnt,
  output logic [2:0] state
);

  localparam int unsigned CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int          CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_LAST  = 2'(MAX_RETRIES);

  logic lock_s;

  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic [7:0]       lost_q, lost_d;
  logic             pll_rst_q, sys_rst_q, running_q, fail_q;

  sync2 u_lock_sync (
    .clk_i (CLK),
    .rst_i (RST),
    .d_i   (pll_lock),
    .q_o   (lock_s)
  );

  // Next-state, counter and status-counter decisions; restart overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_q;
    lost_d  = lost_q;
    case (state_q)
      ST_PLLRST: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TO_LAST) begin
          if (retry_q == RETRY_LAST) begin
            state_d = ST_FAIL;
          end else begin
            retry_d = retry_q + 2'd1;
            state_d = ST_PLLRST;
          end
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          retry_d = 2'd0;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q;
        if (!lock_s) begin
          state_d = ST_PLLRST;
          if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
        end
      end
      ST_FAIL: begin
        cnt_d = cnt_q;
      end
      default: state_d = ST_PLLRST;
    endcase
    if (restart) begin
      state_d = ST_PLLRST;
      retry_d = 2'd0;
      lost_d  = lost_q;
    end
    if ((state_d != state_q) || restart) cnt_d = '0;
  end

  // State, counters and outputs all load on the same edge from next-state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_PLLRST;
      cnt_q     <= '0;
      retry_q   <= 2'd0;
      lost_q    <= 8'd0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      running_q <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      lost_q    <= lost_d;
      pll_rst_q <= !((state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE) ||
                     (state_d == ST_RUN));
      sys_rst_q <= (state_d != ST_RUN);
      running_q <= (state_d == ST_RUN);
      fail_q    <= (state_d == ST_FAIL);
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign running   = running_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
  assign lost_cnt  = lost_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq with short timing parameters (4/32/8/2).
module tb_pll_rst_seq;

  logic       CLK;
  logic       RST;
  logic       pll_lock;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst;
  logic       running;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [7:0] lost_cnt;
  logic [2:0] state;

  int n_tot;
  int n_bad;

  pll_rst_seq #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .pll_lock  (pll_lock),
    .restart   (restart),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .running   (running),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .lost_cnt  (lost_cnt),
    .state     (state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    n_tot++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    int hi;
    int rises;
    logic prev;
    n_tot    = 0;
    n_bad    = 0;
    RST      = 1'b1;
    pll_lock = 1'b1;
    restart  = 1'b0;

    // reset values
    tick(2);
    chk("rst_state", state, 0);
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_sys_rst", sys_rst, 1);
    chk("rst_running", running, 0);
    chk("rst_fail", fail, 0);
    chk("rst_retry", retry_cnt, 0);
    chk("rst_lost", lost_cnt, 0);

    // lock held high: pll_rst falls after 4 edges, sys_rst after 13
    RST = 1'b0;
    tick(3);
    chk("seq_pll_rst_e3", pll_rst, 1);
    tick(1);
    chk("seq_pll_rst_e4", pll_rst, 0);
    chk("seq_state_e4", state, 1);
    tick(1);
    chk("seq_state_e5", state, 2);
    tick(7);
    chk("seq_sys_rst_e12", sys_rst, 1);
    tick(1);
    chk("seq_state_e13", state, 3);
    chk("seq_sys_rst_e13", sys_rst, 0);
    chk("seq_running_e13", running, 1);
    chk("seq_retry_e13", retry_cnt, 0);

    // lock loss in RUN for 3 cycles
    pll_lock = 1'b0;
    tick(2);
    chk("loss_state_e2", state, 3);
    tick(1);
    chk("loss_state_e3", state, 0);
    chk("loss_sys_rst_e3", sys_rst, 1);
    chk("loss_lost", lost_cnt, 1);
    pll_lock = 1'b1;
    tick(4);
    chk("loss_wait", state, 1);
    tick(1);
    chk("loss_stable", state, 2);
    tick(8);
    chk("loss_run", state, 3);
    chk("loss_running", running, 1);

    // glitch while STABLE at count 5
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    chk("gl_restart_state", state, 0);
    chk("gl_lost_kept", lost_cnt, 1);
    tick(8);
    chk("gl_stable_c3", state, 2);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(1);
    chk("gl_stable_c5", state, 2);
    tick(1);
    chk("gl_back_wait", state, 1);
    chk("gl_retry", retry_cnt, 0);
    tick(1);
    chk("gl_restable", state, 2);
    tick(7);
    chk("gl_stable_c7", state, 2);
    tick(1);
    chk("gl_run", state, 3);

    // no lock: three PLL reset pulses then FAIL
    pll_lock = 1'b0;
    restart  = 1'b1;
    tick(1);
    restart = 1'b0;
    chk("to_start", state, 0);
    chk("to_lost_kept", lost_cnt, 1);
    hi    = 0;
    rises = 0;
    prev  = pll_rst;
    for (int k = 1; k <= 108; k++) begin
      tick(1);
      if (pll_rst) hi++;
      if (pll_rst && !prev) rises++;
      prev = pll_rst;
      if (k == 4)   chk("to_wait0", state, 1);
      if (k == 36)  chk("to_retry1", retry_cnt, 1);
      if (k == 36)  chk("to_pllrst1", state, 0);
      if (k == 40)  chk("to_wait1", state, 1);
      if (k == 72)  chk("to_retry2", retry_cnt, 2);
      if (k == 76)  chk("to_wait2", state, 1);
      if (k == 107) chk("to_sys_rst", sys_rst, 1);
      if (k == 108) chk("to_fail_state", state, 4);
      if (k == 108) chk("to_fail_flag", fail, 1);
    end
    chk("to_pll_rst_hi", hi, 12);
    chk("to_pll_rst_rises", rises, 3);
    pll_lock = 1'b1;
    tick(6);
    chk("fail_hold_state", state, 4);
    chk("fail_hold_pll_rst", pll_rst, 1);
    chk("fail_hold_sys_rst", sys_rst, 1);

    // restart out of FAIL
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    chk("rs_state", state, 0);
    chk("rs_fail", fail, 0);
    chk("rs_retry", retry_cnt, 0);
    tick(4);
    chk("rs_wait", state, 1);
    tick(1);
    chk("rs_stable", state, 2);
    tick(8);
    chk("rs_run", state, 3);
    chk("rs_running", running, 1);

    // RST and restart together while running
    RST     = 1'b1;
    restart = 1'b1;
    tick(1);
    chk("rr_state", state, 0);
    chk("rr_pll_rst", pll_rst, 1);
    chk("rr_sys_rst", sys_rst, 1);
    chk("rr_running", running, 0);
    chk("rr_fail", fail, 0);
    chk("rr_retry", retry_cnt, 0);
    chk("rr_lost", lost_cnt, 0);
    RST     = 1'b0;
    restart = 1'b0;
    tick(4);
    chk("rr_wait", state, 1);
    tick(9);
    chk("rr_run", state, 3);
    chk("rr_lost_after", lost_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
